gf22_sram64_rd_stream: RTL and testbench

Burst read streamer that sits directly downstream of the 64-bit byte-enable GF22 SRAM wrappers and drives their read port. It accepts one burst request at a time, meaning a start address and a word count. It issues one read per cycle on the wrapper's CE1/A1 port and captures Q1, which has one-cycle latency, into a small FIFO. The words are presented as a valid/ready stream with a last flag, and downstream backpressure is absorbed without dropping data or stalling the memory mid-read.

---
 rtl/gf22_sram_rd_pkg.sv | 21 ++
 rtl/gf22_sram_rd_fifo.sv | 47 ++++
 rtl/gf22_sram64_rd_stream.sv | 129 ++++++++++++
 tb/tb_gf22_sram64_rd_stream.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gf22_sram_rd_pkg.sv
// Shared types and default sizing for the GF22 SRAM burst read streamer.
// The entry type is the FIFO word layout for the default data width.
package gf22_sram_rd_pkg;

  localparam int ABITS_DEF = 14;
  localparam int DW_DEF    = 64;
  localparam int LEN_W_DEF = 15;
  localparam int DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } rd_state_e;

  typedef struct packed {
    logic              last;
    logic [DW_DEF-1:0] data;
  } rd_entry_t;

endpackage

// File: rtl/gf22_sram_rd_fifo.sv
// Synchronous FIFO holding captured read words with their last tag.
// No bypass: a word pushed in one cycle is visible at the head the next cycle.
module gf22_sram_rd_fifo #(
  parameter int W     = 65,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          CLK,
  input  logic          rstn,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign do_push = push && (count != CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge CLK) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/gf22_sram64_rd_stream.sv
// Burst read streamer: issues one SRAM read per cycle under a credit limit and
// presents the captured words as a valid/ready stream with a last flag.
module gf22_sram64_rd_stream
  import gf22_sram_rd_pkg::*;
#(
  parameter int ABITS = ABITS_DEF,
  parameter int DW    = DW_DEF,
  parameter int LEN_W = LEN_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             CLK,
  input  logic             rstn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [ABITS-1:0] req_addr,
  input  logic [LEN_W-1:0] req_len,
  output logic             mem_CE1,
  output logic [ABITS-1:0] mem_A1,
  input  logic [DW-1:0]    mem_Q1,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [DW-1:0]    rd_data,
  output logic             rd_last,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready, and data is stable while valid waits.

  localparam int CW = $clog2(DEPTH) + 1;

  rd_state_e        state_q, state_d;
  logic [ABITS-1:0] cur_addr_q;
  logic [ABITS-1:0] a1_q;
  logic [LEN_W-1:0] remaining_q;
  logic             inflight_q;
  logic             inflight_last_q;
  logic             done_q;

  logic [DW:0]      fifo_head;
  logic [CW-1:0]    fifo_count;
  logic             fifo_empty;
  logic [CW:0]      occupancy;
  logic             credit_ok;
  logic             accept;
  logic             pop;
  logic             head_last;
  logic             last_issue;

  // Credit counts the word already in the SRAM pipe so a push can never overflow.
  assign occupancy  = {1'b0, fifo_count} + (CW+1)'(inflight_q);
  assign credit_ok  = occupancy < (CW+1)'(DEPTH);
  assign accept     = req_valid && req_ready;
  assign pop        = rd_valid && rd_ready;
  assign head_last  = fifo_head[DW];
  assign last_issue = mem_CE1 && (remaining_q == LEN_W'(1));

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    mem_CE1   = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = rstn;
        if (req_valid && rstn && (req_len != '0)) state_d = ISSUE;
      end
      ISSUE: begin
        mem_CE1 = credit_ok;
        if (credit_ok && (remaining_q == LEN_W'(1))) state_d = DRAIN;
      end
      DRAIN: begin
        if (pop && head_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!rstn) begin
      state_q         <= IDLE;
      cur_addr_q      <= '0;
      a1_q            <= '0;
      remaining_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      inflight_q      <= mem_CE1;
      inflight_last_q <= last_issue;
      done_q          <= (accept && (req_len == '0)) ||
                         ((state_q == DRAIN) && pop && head_last);
      if (accept) begin
        cur_addr_q  <= req_addr;
        remaining_q <= req_len;
      end else if (mem_CE1) begin
        cur_addr_q  <= cur_addr_q + 1'b1;
        remaining_q <= remaining_q - 1'b1;
        a1_q        <= cur_addr_q;
      end
    end
  end

  gf22_sram_rd_fifo #(
    .W     (DW + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK       (CLK),
    .rstn      (rstn),
    .push      (inflight_q),
    .push_data ({inflight_last_q, mem_Q1}),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  // Address holds the last issued value while idle so the SRAM pins stay quiet.
  assign mem_A1    = mem_CE1 ? cur_addr_q : a1_q;
  assign rd_valid  = !fifo_empty;
  assign rd_data   = rd_valid ? fifo_head[DW-1:0] : '0;
  assign rd_last   = rd_valid && head_last;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_gf22_sram64_rd_stream.sv
// Bench for gf22_sram64_rd_stream: SRAM model, burst vector table, hand-built
// corner sequences and a queue-based scoreboard of expected words and addresses.
module tb_gf22_sram64_rd_stream;
  import gf22_sram_rd_pkg::*;

  localparam int ABITS = 14;
  localparam int DW    = 64;
  localparam int LEN_W = 15;
  localparam int DEPTH = 4;

  logic             CLK = 1'b0;
  logic             rstn;
  logic             req_valid;
  logic             req_ready;
  logic [ABITS-1:0] req_addr;
  logic [LEN_W-1:0] req_len;
  logic             mem_CE1;
  logic [ABITS-1:0] mem_A1;
  logic [DW-1:0]    mem_Q1;
  logic             rd_valid;
  logic             rd_ready;
  logic [DW-1:0]    rd_data;
  logic             rd_last;
  logic             busy;
  logic             done;
  logic [1:0]       dbg_state;

  gf22_sram64_rd_stream #(
    .ABITS(ABITS), .DW(DW), .LEN_W(LEN_W), .DEPTH(DEPTH)
  ) dut (
    .CLK(CLK), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_len(req_len),
    .mem_CE1(mem_CE1), .mem_A1(mem_A1), .mem_Q1(mem_Q1),
    .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_last(rd_last),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // clock / reset-independent infrastructure
  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int ready_pct = 100;

  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] mem_word(input logic [ABITS-1:0] a);
    logic [31:0] h;
    h = {18'd0, a} * 32'h9E37_79B1;
    return {16'hC0DE, 2'b00, a, h};
  endfunction

  // SRAM model: one-cycle read latency
  always @(posedge CLK) begin
    if (mem_CE1) mem_Q1 <= mem_word(mem_A1);
  end

  always @(posedge CLK) begin
    #2;
    rd_ready = (ready_pct >= 100) ? 1'b1 : ($urandom_range(99) < ready_pct);
  end

  task automatic check(input string name, input logic [DW:0] got, input logic [DW:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // scoreboard
  logic [DW:0]      exp_q[$];
  logic [ABITS-1:0] exp_addr_q[$];
  int outstanding = 0;
  int ce_log[$];
  int pop_log[$];
  int last_log[$];
  int done_log[$];

  always @(negedge CLK) begin
    if (!rstn) begin
      exp_q.delete();
      exp_addr_q.delete();
      outstanding = 0;
    end else begin
      if (mem_CE1) begin
        ce_log.push_back(cyc);
        check("credit", outstanding < DEPTH, 1'b1);
        check("ce_only_busy", busy, 1'b1);
        if (exp_addr_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL extra_issue: mem_A1=%0h issued, expected no read", mem_A1);
        end else begin
          check("mem_A1", mem_A1, exp_addr_q.pop_front());
        end
      end
      if (rd_valid && rd_ready) begin
        pop_log.push_back(cyc);
        if (rd_last) last_log.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL extra_pop: got=%0h expected no word", {rd_last, rd_data});
        end else begin
          check("rd_word", {rd_last, rd_data}, exp_q.pop_front());
        end
      end
      if (done) begin
        done_log.push_back(cyc);
        check("ready_at_done", req_ready, 1'b1);
      end
      outstanding = outstanding + (mem_CE1 ? 1 : 0) - ((rd_valid && rd_ready) ? 1 : 0);
    end
  end

  // driver tasks (caller is always just after a rising edge)
  task automatic start_burst(input logic [ABITS-1:0] addr, input int len, output int acc_cyc);
    int guard;
    logic [ABITS-1:0] a;
    guard = 0;
    while (!req_ready && guard < 300) begin
      @(posedge CLK); #1;
      guard++;
    end
    check("req_ready_before_start", req_ready, 1'b1);
    ce_log.delete();
    pop_log.delete();
    last_log.delete();
    done_log.delete();
    for (int i = 0; i < len; i++) begin
      a = ABITS'((int'(addr) + i) % (1 << ABITS));
      exp_addr_q.push_back(a);
      exp_q.push_back({(i == len - 1), mem_word(a)});
    end
    req_valid = 1'b1;
    req_addr  = addr;
    req_len   = LEN_W'(len);
    @(posedge CLK); #1;
    req_valid = 1'b0;
    acc_cyc   = cyc;
  endtask

  task automatic wait_done(input int len, output int done_cyc);
    int guard;
    guard = 0;
    while (done_log.size() == 0 && guard < 20 * len + 60) begin
      @(posedge CLK); #1;
      guard++;
    end
    if (done_log.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: no done after %0d cycles, expected one", guard);
      done_cyc = -1;
    end else begin
      done_cyc = done_log[0];
    end
    @(posedge CLK); #1;
    check("done_pulse_count", done_log.size(), 1);
    check("words_left", exp_q.size(), 0);
    check("issues_left", exp_addr_q.size(), 0);
    check("pop_count", pop_log.size(), len);
    check("last_count", last_log.size(), (len > 0) ? 1 : 0);
  endtask

  typedef struct {
    logic [ABITS-1:0] addr;
    int               len;
    int               pct;
    int               exp_done;   // cycle of done after accept, 0 = not checked
    int               exp_first;  // cycle of first pop after accept, 0 = not checked
  } vec_t;

  vec_t vecs[$];

  initial begin
    int acc;
    int dcyc;
    vec_t v;

    rstn      = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_len   = '0;

    // reset
    repeat (3) @(posedge CLK);
    #1;
    check("req_ready_in_reset", req_ready, 1'b0);
    rstn = 1'b1;
    #1;
    check("rst_rd_valid", rd_valid, 1'b0);
    check("rst_rd_data", rd_data, '0);
    check("rst_mem_CE1", mem_CE1, 1'b0);
    check("rst_mem_A1", mem_A1, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_req_ready", req_ready, 1'b1);
    @(posedge CLK); #1;

    // single burst, cycle-exact
    start_burst(14'h0010, 4, acc);
    wait_done(4, dcyc);
    check("single_done_cycle", dcyc - acc + 1, 7);
    for (int i = 0; i < 4; i++) begin
      if (i < ce_log.size()) check("single_issue_cycle", ce_log[i] - acc + 1, i + 1);
      if (i < pop_log.size()) check("single_pop_cycle", pop_log[i] - acc + 1, i + 3);
    end
    if (last_log.size() > 0) check("single_last_cycle", last_log[0] - acc + 1, 6);

    // table of bursts
    vecs.push_back('{14'h3FFE, 4,   100, 7, 3});
    vecs.push_back('{14'h0000, 0,   100, 1, 0});
    vecs.push_back('{14'h1234, 1,   100, 4, 3});
    vecs.push_back('{14'h0777, 2,   100, 5, 3});
    vecs.push_back('{14'h2000, 256, 50,  0, 0});
    vecs.push_back('{14'h3FFF, 9,   70,  0, 0});
    vecs.push_back('{14'h0abc, 0,   30,  1, 0});
    for (int i = 0; i < 4; i++) begin
      v.addr = ABITS'($urandom_range(0, (1 << ABITS) - 1));
      v.len  = $urandom_range(1, 40);
      v.pct  = (i < 2) ? 100 : $urandom_range(20, 90);
      v.exp_done  = (v.pct == 100) ? v.len + 3 : 0;
      v.exp_first = (v.pct == 100) ? 3 : 0;
      vecs.push_back(v);
    end

    foreach (vecs[k]) begin
      ready_pct = vecs[k].pct;
      @(posedge CLK); #1;
      start_burst(vecs[k].addr, vecs[k].len, acc);
      wait_done(vecs[k].len, dcyc);
      check("issue_count", ce_log.size(), vecs[k].len);
      if (vecs[k].exp_done > 0) check("done_cycle", dcyc - acc + 1, vecs[k].exp_done);
      if (vecs[k].exp_first > 0 && pop_log.size() > 0)
        check("first_data_cycle", pop_log[0] - acc + 1, vecs[k].exp_first);
    end

    // backpressure: consumer stalled for the first 10 cycles
    ready_pct = 0;
    @(posedge CLK); #1;
    start_burst(14'h0400, 16, acc);
    repeat (9) begin
      @(posedge CLK); #1;
    end
    check("bp_issues_before_pop", ce_log.size(), DEPTH);
    check("bp_no_pop_while_stalled", pop_log.size(), 0);
    ready_pct = 100;
    wait_done(16, dcyc);
    check("bp_issue_count", ce_log.size(), 16);

    // reset in the middle of a burst
    ready_pct = 100;
    @(posedge CLK); #1;
    start_burst(14'h0200, 32, acc);
    for (int g = 0; g < 100 && pop_log.size() < 5; g++) begin
      @(posedge CLK); #1;
    end
    check("mid_pops_before_reset", pop_log.size() >= 5, 1'b1);
    rstn = 1'b0;
    #1;
    check("req_ready_during_reset", req_ready, 1'b0);
    @(posedge CLK); #1;
    rstn = 1'b1;
    #1;
    check("mid_rst_rd_valid", rd_valid, 1'b0);
    check("mid_rst_rd_last", rd_last, 1'b0);
    check("mid_rst_rd_data", rd_data, '0);
    check("mid_rst_mem_CE1", mem_CE1, 1'b0);
    check("mid_rst_mem_A1", mem_A1, '0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_req_ready", req_ready, 1'b1);
    @(posedge CLK); #1;
    start_burst(14'h0100, 2, acc);
    wait_done(2, dcyc);
    check("post_reset_done_cycle", dcyc - acc + 1, 5);
    check("post_reset_issue_count", ce_log.size(), 2);

    repeat (3) @(posedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
